// File: rtl/prog_loader.sv
// Boot loader: streams 32-bit words into imem and 64-bit words into dmem, then runs the cpu.
// Optional PROG_LOADER_CHECKSUM_EN adds a stream checksum that gates the run.
module prog_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [10:0]      imem_len,
  input  logic [10:0]      dmem_len,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             halt,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic [63:0]      imem_addr,
  output logic             imem_wen,
  output logic [31:0]      imem_wdata,
  output logic [63:0]      dmem_addr,
  output logic             dmem_wen,
  output logic [63:0]      dmem_wdata,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic [31:0]      exp_sum,
  output logic [31:0]      sum,
  output logic             sum_err,
`endif
  output logic [CNT_W-1:0] cycle_count
);

  // FLUSH is a one-cycle gap so the last write strobe retires before cpu_enable rises.
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_DL, LOAD_DH, FLUSH, RUN, DONE} state_t;

  localparam logic [10:0]      IMAX = 11'(IMEM_DEPTH);
  localparam logic [10:0]      DMAX = 11'(DMEM_DEPTH);
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [10:0] ilen, dlen, icnt, dcnt;
  logic [31:0] lo;
  logic [10:0] il_c, dl_c;
  logic        take, start_go, chk_ok;

  assign il_c     = (imem_len > IMAX) ? IMAX : imem_len;
  assign dl_c     = (dmem_len > DMAX) ? DMAX : dmem_len;
  assign s_ready  = (state == LOAD_I) || (state == LOAD_DL) || (state == LOAD_DH);
  assign take     = s_valid && s_ready;
  assign start_go = start && ((state == IDLE) || (state == DONE));
  assign cpu_enable = (state == RUN);
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] exp_q;
  assign chk_ok = (sum == exp_q);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sum     <= '0;
      sum_err <= 1'b0;
      exp_q   <= '0;
    end else if (start_go) begin
      sum     <= '0;
      sum_err <= 1'b0;
      exp_q   <= exp_sum;
    end else begin
      if (take) sum <= sum + s_data;
      if (state == FLUSH && !chk_ok) sum_err <= 1'b1;
    end
  end
`else
  assign chk_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      ilen        <= '0;
      dlen        <= '0;
      icnt        <= '0;
      dcnt        <= '0;
      lo          <= '0;
      imem_addr   <= '0;
      imem_wen    <= 1'b0;
      imem_wdata  <= '0;
      dmem_addr   <= '0;
      dmem_wen    <= 1'b0;
      dmem_wdata  <= '0;
      cycle_count <= '0;
    end else begin
      imem_wen <= 1'b0;
      dmem_wen <= 1'b0;
      case (state)
        IDLE, DONE: if (start_go) begin
          ilen        <= il_c;
          dlen        <= dl_c;
          icnt        <= '0;
          dcnt        <= '0;
          imem_addr   <= '0;
          dmem_addr   <= '0;
          cycle_count <= '0;
          if (il_c != '0)      state <= LOAD_I;
          else if (dl_c != '0) state <= LOAD_DL;
          else                 state <= FLUSH;
        end
        LOAD_I: if (take) begin
          imem_wen   <= 1'b1;
          imem_wdata <= s_data;
          imem_addr  <= {51'b0, icnt, 2'b00};
          icnt       <= icnt + 11'd1;
          if (icnt == ilen - 11'd1) state <= (dlen != '0) ? LOAD_DL : FLUSH;
        end
        LOAD_DL: if (take) begin
          lo    <= s_data;
          state <= LOAD_DH;
        end
        LOAD_DH: if (take) begin
          dmem_wen   <= 1'b1;
          dmem_wdata <= {s_data, lo};
          dmem_addr  <= {50'b0, dcnt, 3'b000};
          dcnt       <= dcnt + 11'd1;
          state      <= (dcnt == dlen - 11'd1) ? FLUSH : LOAD_DL;
        end
        FLUSH: state <= chk_ok ? RUN : DONE;
        RUN: begin
          if (~&cycle_count) cycle_count <= cycle_count + ONE;
          if (halt || (run_cycles != '0 && cycle_count == run_cycles - ONE)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a negedge monitor records write strobes and enable
// cycles; each scenario task compares against hand-computed values.
module tb_prog_loader;
  logic        clk = 0, arst_n = 0, start = 0, halt = 0, s_valid = 0;
  logic [10:0] imem_len = 0, dmem_len = 0;
  logic [31:0] run_cycles = 0, s_data = 0, exp_sum = 0;
  logic        s_ready, imem_wen, dmem_wen, cpu_enable, busy, done;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata;
  logic [31:0] imem_wdata, cycle_count;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_err;
`endif

  int vecs = 0, errs = 0, en_cycles = 0;
  logic [63:0] iw_addr[$], dw_addr[$], dw_data[$];
  logic [31:0] iw_data[$];

  prog_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_len(imem_len), .dmem_len(dmem_len),
    .run_cycles(run_cycles), .halt(halt), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .cpu_enable(cpu_enable), .busy(busy), .done(done),
`ifdef PROG_LOADER_CHECKSUM_EN
    .exp_sum(exp_sum), .sum(sum), .sum_err(sum_err),
`endif
    .cycle_count(cycle_count));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wen) begin iw_addr.push_back(imem_addr); iw_data.push_back(imem_wdata); end
    if (dmem_wen) begin dw_addr.push_back(dmem_addr); dw_data.push_back(dmem_wdata); end
    if (cpu_enable) en_cycles++;
  end

  task automatic clear_log();
    iw_addr.delete(); iw_data.delete(); dw_addr.delete(); dw_data.delete(); en_cycles = 0;
  endtask

  task automatic do_start(input int il, input int dl, input int rc, input logic [31:0] es);
    imem_len = 11'(il); dmem_len = 11'(dl); run_cycles = rc; exp_sum = es; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    bit ok = 0;
    s_valid = 1; s_data = w;
    for (int i = 0; i < 100; i++) begin
      if (s_ready) begin @(negedge clk); ok = 1; break; end
      @(negedge clk);
    end
    s_valid = 0;
    if (!ok) begin vecs++; errs++; $display("FAIL handshake_timeout word=%h", w); end
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL done_timeout got done=%b want 1", done); end
  endtask

  task automatic test_reset();
    vecs++; if (imem_addr !== 64'd0 || imem_wen !== 1'b0 || imem_wdata !== 32'd0) begin
      errs++; $display("FAIL reset_imem got %h/%b/%h want 0", imem_addr, imem_wen, imem_wdata); end
    vecs++; if (dmem_addr !== 64'd0 || dmem_wen !== 1'b0 || dmem_wdata !== 64'd0) begin
      errs++; $display("FAIL reset_dmem got %h/%b/%h want 0", dmem_addr, dmem_wen, dmem_wdata); end
    vecs++; if ({s_ready, cpu_enable, busy, done} !== 4'b0 || cycle_count !== 32'd0) begin
      errs++; $display("FAIL reset_ctl got %b cnt=%0d want 0", {s_ready, cpu_enable, busy, done}, cycle_count); end
  endtask

  task automatic test_imem_run();
    logic [31:0] w[3] = '{32'h00000013, 32'h00100093, 32'h00208113};
    clear_log();
    do_start(3, 0, 10, 32'h003081B9);
    for (int i = 0; i < 3; i++) send_word(w[i], 0);
    wait_done(100);
    vecs++; if (iw_addr.size() != 3 || dw_addr.size() != 0) begin
      errs++; $display("FAIL imem_count got %0d/%0d want 3/0", iw_addr.size(), dw_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      vecs++; if (iw_addr[i] !== 64'(4 * i) || iw_data[i] !== w[i]) begin
        errs++; $display("FAIL imem_write%0d got %h@%h want %h@%h", i, iw_data[i], iw_addr[i], w[i], 4 * i); end
    end
    vecs++; if (en_cycles != 10 || cycle_count !== 32'd10) begin
      errs++; $display("FAIL run_limit got en=%0d cnt=%0d want 10/10", en_cycles, cycle_count); end
    vecs++; if (cpu_enable !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL done_state got en=%b busy=%b want 0/0", cpu_enable, busy); end
  endtask

  task automatic test_dmem_gaps();
    clear_log();
    do_start(0, 2, 5, 32'd10);
    for (int i = 1; i <= 4; i++) send_word(32'(i), 2);
    wait_done(100);
    vecs++; if (dw_addr.size() != 2 || iw_addr.size() != 0) begin
      errs++; $display("FAIL dmem_count got %0d/%0d want 2/0", dw_addr.size(), iw_addr.size()); end
    else begin
      vecs++; if (dw_addr[0] !== 64'd0 || dw_data[0] !== 64'h0000000200000001) begin
        errs++; $display("FAIL dmem_write0 got %h@%h want 0000000200000001@0", dw_data[0], dw_addr[0]); end
      vecs++; if (dw_addr[1] !== 64'd8 || dw_data[1] !== 64'h0000000400000003) begin
        errs++; $display("FAIL dmem_write1 got %h@%h want 0000000400000003@8", dw_data[1], dw_addr[1]); end
    end
  endtask

  task automatic test_halt();
    bit hit = 0;
    clear_log();
    do_start(1, 0, 0, 32'h77);
    send_word(32'h77, 0);
    for (int i = 0; i < 200; i++) begin
      if (cpu_enable && cycle_count == 32'd24) begin hit = 1; break; end
      @(negedge clk);
    end
    halt = 1;
    @(negedge clk);
    halt = 0;
    vecs++; if (!hit) begin errs++; $display("FAIL halt_wait got no cycle 24 want reached"); end
    vecs++; if (done !== 1'b1 || cycle_count !== 32'd25 || en_cycles != 25) begin
      errs++; $display("FAIL halt got done=%b cnt=%0d en=%0d want 1/25/25", done, cycle_count, en_cycles); end
  endtask

  task automatic test_reset_mid();
    do_start(4, 0, 5, 32'h0);
    send_word(32'hDEAD0000, 0);
    send_word(32'hDEAD0001, 0);
    @(negedge clk);
    arst_n = 0;
    #1;
    vecs++; if (imem_addr !== 64'd0 || {imem_wen, s_ready, busy, cpu_enable} !== 4'b0) begin
      errs++; $display("FAIL midreset_out got addr=%h ctl=%b want 0", imem_addr, {imem_wen, s_ready, busy, cpu_enable}); end
    clear_log();
    s_valid = 1; s_data = 32'hBAD;
    repeat (3) @(negedge clk);
    s_valid = 0;
    arst_n = 1;
    @(negedge clk);
    vecs++; if (iw_addr.size() != 0) begin
      errs++; $display("FAIL midreset_strobes got %0d want 0", iw_addr.size()); end
    do_start(2, 0, 3, 32'h15);
    send_word(32'hA, 0);
    send_word(32'hB, 0);
    wait_done(100);
    vecs++; if (iw_addr.size() != 2 || iw_addr[0] !== 64'd0 || iw_addr[1] !== 64'd4 || iw_data[1] !== 32'hB) begin
      errs++; $display("FAIL reload got n=%0d a0=%h want n=2 a0=0 a1=4", iw_addr.size(), iw_addr.size() > 0 ? iw_addr[0] : 64'hX); end
  endtask

  task automatic test_clamp();
    bit hit = 0;
    clear_log();
    do_start(1000, 0, 3, 32'h1FF00);
    for (int i = 0; i < 512; i++) send_word(32'(i), 0);
    for (int i = 0; i < 20; i++) begin
      if (cpu_enable) begin hit = 1; break; end
      @(negedge clk);
    end
    start = 1; imem_len = 11'd5;
    @(negedge clk);
    start = 0;
    vecs++; if (!hit || cpu_enable !== 1'b1 || s_ready !== 1'b0 || cycle_count !== 32'd1) begin
      errs++; $display("FAIL start_in_run got en=%b rdy=%b cnt=%0d want 1/0/1", cpu_enable, s_ready, cycle_count); end
    wait_done(50);
    vecs++; if (iw_addr.size() != 512) begin
      errs++; $display("FAIL clamp_count got %0d want 512", iw_addr.size()); end
    else begin
      vecs++; if (iw_addr[511] !== 64'h7FC || iw_data[511] !== 32'd511) begin
        errs++; $display("FAIL clamp_last got %h@%h want 1ff@7fc", iw_data[511], iw_addr[511]); end
    end
    vecs++; if (en_cycles != 3 || cycle_count !== 32'd3) begin
      errs++; $display("FAIL clamp_run got en=%0d cnt=%0d want 3/3", en_cycles, cycle_count); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    do_start(2, 0, 10, 32'd4);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    wait_done(20);
    vecs++; if (sum !== 32'd3 || sum_err !== 1'b1 || en_cycles != 0) begin
      errs++; $display("FAIL checksum got sum=%0d err=%b en=%0d want 3/1/0", sum, sum_err, en_cycles); end
  endtask
`endif

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    arst_n = 1;
    @(negedge clk);
    test_imem_run();
    test_dmem_gaps();
    test_halt();
    test_reset_mid();
    test_clamp();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
